seg_scan_ctrl: RTL

//  Scan controller for the shared two-digit 7-segment display of the dice design.
//  - Time-multiplexes the ones and tens digits onto one segment bus, with blanking dead-time between slots.
//  - Arbitrates between the dice result path and the raw-segment override written by the I2C slave.
//  - Applies the configured segment and common polarities.
//  - Takes all new inputs only at frame boundaries, so a frame never shows mixed (torn) content.

---
 rtl/dice_pkg.sv | 42 ++++
 rtl/seg7_encoder.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types and constants for the dice display path.
// Segment fonts, scan states and per-frame config bundle.
package dice_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  typedef enum logic [1:0] {
    GAP1,
    ONES,
    GAP2,
    TENS
  } scan_state_t;

  // Everything that is frozen for the length of one frame.
  typedef struct packed {
    logic       ovr_en;
    logic [6:0] seg1;
    logic [6:0] seg10;
    logic       seg_pol;
    logic       com_pol;
    logic       lzb;
  } frame_cfg_t;

  // Apply segment polarity; dp is always driven inactive.
  function automatic logic [7:0] drive_seg(
    input logic       pol,
    input logic [6:0] pat
  );
    return pol ? {1'b0, pat} : ~{1'b0, pat};
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// BCD to 7-segment {g..a} pattern.
// Codes 10-15 give a blank pattern and lit = 0.
module seg7_encoder
  import dice_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pat,
  output logic       lit
);

  // Font lookup; out-of-range codes are dark.
  always_comb begin
    pat = SEG7_BLANK;
    lit = 1'b1;
    case (bcd)
      4'd0:    pat = SEG7_0;
      4'd1:    pat = SEG7_1;
      4'd2:    pat = SEG7_2;
      4'd3:    pat = SEG7_3;
      4'd4:    pat = SEG7_4;
      4'd5:    pat = SEG7_5;
      4'd6:    pat = SEG7_6;
      4'd7:    pat = SEG7_7;
      4'd8:    pat = SEG7_8;
      4'd9:    pat = SEG7_9;
      default: begin
        pat = SEG7_BLANK;
        lit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit 7-segment scan controller with gap blanking,
// override arbitration and frame-atomic input capture.
module seg_scan_ctrl
  import dice_pkg::*;
#(
  parameter int SCAN_DIV   = 1024,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit1_in,
  input  logic [3:0] digit10_in,
  input  logic       digit_valid,
  input  logic       ovr_en,
  input  logic [6:0] ovr_seg1,
  input  logic [6:0] ovr_seg10,
  input  logic       cfg_seg_pol,
  input  logic       cfg_com_pol,
  input  logic       cfg_lzb,
  output logic [7:0] seg_out,
  output logic       com1_out,
  output logic       com10_out,
  output logic [1:0] com_oe,
  output logic       frame_tick
);

  localparam int MAXD =
    (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CW = $clog2(MAXD);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    DIG_BLANK = 4'hF;

  scan_state_t state;
  scan_state_t nxt_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt_cnt;

  logic [3:0] pend1;
  logic [3:0] pend10;
  logic [3:0] sh1;
  logic [3:0] sh10;
  logic [3:0] nxt_sh1;
  logic [3:0] nxt_sh10;

  frame_cfg_t fr;
  frame_cfg_t nxt_fr;
  frame_cfg_t in_cfg;

  logic       boundary;
  logic [6:0] enc1_pat;
  logic [6:0] enc10_pat;
  logic       enc1_lit;
  logic       enc10_lit;
  logic       lit1;
  logic       lit10;
  logic [6:0] pat1;
  logic [6:0] pat10;
  logic [6:0] nxt_pat;
  logic       nxt_on1;
  logic       nxt_on10;
  logic [7:0] nxt_seg;
  logic       nxt_com1;
  logic       nxt_com10;
  logic       nxt_tick;

  assign in_cfg = '{
    ovr_en:  ovr_en,
    seg1:    ovr_seg1,
    seg10:   ovr_seg10,
    seg_pol: cfg_seg_pol,
    com_pol: cfg_com_pol,
    lzb:     cfg_lzb
  };

  assign boundary = (state == GAP1) && (cnt == '0);

  // Slot sequencing: gap/ones/gap/tens, counter cleared on change.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CW'(1);
    case (state)
      GAP1: if (cnt == GAP_LAST) begin
        nxt_state = ONES;
        nxt_cnt   = '0;
      end
      ONES: if (cnt == SLOT_LAST) begin
        nxt_state = GAP2;
        nxt_cnt   = '0;
      end
      GAP2: if (cnt == GAP_LAST) begin
        nxt_state = TENS;
        nxt_cnt   = '0;
      end
      TENS: if (cnt == SLOT_LAST) begin
        nxt_state = GAP1;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Frame-boundary capture; a strobe on the boundary bypasses pending.
  always_comb begin
    nxt_sh1  = sh1;
    nxt_sh10 = sh10;
    nxt_fr   = fr;
    if (boundary) begin
      nxt_sh1  = digit_valid ? digit1_in  : pend1;
      nxt_sh10 = digit_valid ? digit10_in : pend10;
      nxt_fr   = in_cfg;
    end
  end

  seg7_encoder u_enc1 (
    .bcd (nxt_sh1),
    .pat (enc1_pat),
    .lit (enc1_lit)
  );

  seg7_encoder u_enc10 (
    .bcd (nxt_sh10),
    .pat (enc10_pat),
    .lit (enc10_lit)
  );

  // Slot content arbitration: override, then leading-zero, then font.
  always_comb begin
    lit1  = nxt_fr.ovr_en | enc1_lit;
    pat1  = nxt_fr.ovr_en ? nxt_fr.seg1 : enc1_pat;
    lit10 = nxt_fr.ovr_en |
            (enc10_lit & ~(nxt_fr.lzb & (nxt_sh10 == 4'd0)));
    pat10 = nxt_fr.ovr_en ? nxt_fr.seg10 :
            (lit10 ? enc10_pat : SEG7_BLANK);
  end

  // Output image for the coming cycle, polarity applied.
  always_comb begin
    nxt_pat  = SEG7_BLANK;
    nxt_on1  = 1'b0;
    nxt_on10 = 1'b0;
    case (nxt_state)
      ONES: begin
        nxt_on1 = lit1;
        nxt_pat = lit1 ? pat1 : SEG7_BLANK;
      end
      TENS: begin
        nxt_on10 = lit10;
        nxt_pat  = lit10 ? pat10 : SEG7_BLANK;
      end
      default: begin
        nxt_pat = SEG7_BLANK;
      end
    endcase
    nxt_seg   = drive_seg(nxt_fr.seg_pol, nxt_pat);
    nxt_com1  = nxt_on1  ? nxt_fr.com_pol : ~nxt_fr.com_pol;
    nxt_com10 = nxt_on10 ? nxt_fr.com_pol : ~nxt_fr.com_pol;
    nxt_tick  = (nxt_state == GAP1) && (nxt_cnt == '0);
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GAP1;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  // Pending/shadow digits and frame config; last strobe wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend1  <= DIG_BLANK;
      pend10 <= DIG_BLANK;
      sh1    <= DIG_BLANK;
      sh10   <= DIG_BLANK;
      fr     <= in_cfg;
    end else begin
      if (digit_valid) begin
        pend1  <= digit1_in;
        pend10 <= digit10_in;
      end
      sh1  <= nxt_sh1;
      sh10 <= nxt_sh10;
      fr   <= nxt_fr;
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= {8{~cfg_seg_pol}};
      com1_out   <= ~cfg_com_pol;
      com10_out  <= ~cfg_com_pol;
      com_oe     <= 2'b00;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= nxt_seg;
      com1_out   <= nxt_com1;
      com10_out  <= nxt_com10;
      com_oe     <= 2'b11;
      frame_tick <= nxt_tick;
    end
  end

endmodule
